// File: rtl/timer_count_sequencer_pkg.sv
// Shared timer types and constants, also used by the VGA digit renderer.
// Optional expiry blink is enabled with TIMER_EXPIRE_BLINK_EN.
package timer_pkg;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int SEC_ONES_MAX = 9;

    typedef struct packed {
        logic [BCD_W-1:0] min_tens;
        logic [BCD_W-1:0] min_ones;
        logic [BCD_W-1:0] sec_tens;
        logic [BCD_W-1:0] sec_ones;
    } time_bcd_t;

    function automatic int prescale_max(input int clk_hz, input int tick_hz);
        return (clk_hz / tick_hz) - 1;
    endfunction

endpackage

// File: rtl/timer_count_sequencer_if.sv
// Command/status bundle between the timer control FSM and the count sequencer.
// Carries the blink status line when TIMER_EXPIRE_BLINK_EN is defined.
interface timer_count_sequencer_if;
    import timer_pkg::*;

    logic             resetTimer;
    logic             enableCounter;
    logic             forward;
    logic             incrementSeg;
    logic             incrementMin;
    logic [BCD_W-1:0] sec_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] min_tens;
    logic             tick;
    logic             finish;
    logic             zero;
`ifdef TIMER_EXPIRE_BLINK_EN
    logic             blink;

    modport master (
        output resetTimer, enableCounter, forward, incrementSeg, incrementMin,
        input  sec_ones, sec_tens, min_ones, min_tens, tick, finish, zero, blink
    );
    modport slave (
        input  resetTimer, enableCounter, forward, incrementSeg, incrementMin,
        output sec_ones, sec_tens, min_ones, min_tens, tick, finish, zero, blink
    );
`else
    modport master (
        output resetTimer, enableCounter, forward, incrementSeg, incrementMin,
        input  sec_ones, sec_tens, min_ones, min_tens, tick, finish, zero
    );
    modport slave (
        input  resetTimer, enableCounter, forward, incrementSeg, incrementMin,
        output sec_ones, sec_tens, min_ones, min_tens, tick, finish, zero
    );
`endif

endinterface

// File: rtl/timer_count_sequencer_tick_prescaler.sv
// Divide-by-DIV prescaler; tick is high during the terminal-count cycle.
// free_run input exists only when TIMER_EXPIRE_BLINK_EN is defined.
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
`ifdef TIMER_EXPIRE_BLINK_EN
    input  logic free_run,
`endif
    output logic tick
);

    localparam int           W   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] MAX = W'(DIV - 1);

    logic [W-1:0] cnt;
    logic         adv;

`ifdef TIMER_EXPIRE_BLINK_EN
    assign adv = run | free_run;
`else
    assign adv = run;
`endif

    // Holding when not advancing keeps the partial second across pauses.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= (cnt == MAX) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = adv && (cnt == MAX);

endmodule

// File: rtl/timer_count_sequencer.sv
// MM:SS BCD time register driven by the timer control FSM's command levels.
// Define TIMER_EXPIRE_BLINK_EN to add the expiry blink output.
module timer_count_sequencer
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int MIN_MAX = 99
) (
    input logic                    clk,
    input logic                    reset,
    timer_count_sequencer_if.slave bus
);

    localparam int               DIV       = prescale_max(CLK_HZ, TICK_HZ) + 1;
    localparam logic [BCD_W-1:0] MT_MAX    = BCD_W'(MIN_MAX / 10);
    localparam logic [BCD_W-1:0] MO_MAX    = BCD_W'(MIN_MAX % 10);
    localparam logic [BCD_W-1:0] ST_MAX    = BCD_W'(SEC_TENS_MAX);
    localparam logic [BCD_W-1:0] SO_MAX    = BCD_W'(SEC_ONES_MAX);
    localparam logic [BCD_W-1:0] NINE      = BCD_W'(9);
    localparam time_bcd_t        ONE_SEC   = time_bcd_t'(16'h0001);

    time_bcd_t cur_t;
    time_bcd_t nxt_t;
    logic      inc_s_d, inc_m_d;
    logic      inc_s_edge, inc_m_edge;
    logic      setting, counting;
    logic      tick;
    logic      hit_n, hit_q, finish_q;

    assign inc_s_edge = bus.incrementSeg & ~inc_s_d;
    assign inc_m_edge = bus.incrementMin & ~inc_m_d;
    assign setting    = bus.enableCounter & bus.forward;
    assign counting   = bus.enableCounter & ~bus.forward;

`ifdef TIMER_EXPIRE_BLINK_EN
    logic expired;
    logic blink_q;
`endif

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clr      (bus.resetTimer),
        .run      (counting),
`ifdef TIMER_EXPIRE_BLINK_EN
        .free_run (expired),
`endif
        .tick     (tick)
    );

    // One action per cycle: clear beats setting beats countdown.
    always_comb begin
        nxt_t = cur_t;
        hit_n = 1'b0;
        if (bus.resetTimer) begin
            nxt_t = '0;
        end else if (setting) begin
            if (inc_s_edge) begin
                if (cur_t.sec_ones == SO_MAX) begin
                    nxt_t.sec_ones = '0;
                    nxt_t.sec_tens = (cur_t.sec_tens == ST_MAX) ? '0 : cur_t.sec_tens + 1'b1;
                end else begin
                    nxt_t.sec_ones = cur_t.sec_ones + 1'b1;
                end
            end
            if (inc_m_edge) begin
                if (cur_t.min_tens == MT_MAX && cur_t.min_ones == MO_MAX) begin
                    nxt_t.min_tens = '0;
                    nxt_t.min_ones = '0;
                end else if (cur_t.min_ones == NINE) begin
                    nxt_t.min_ones = '0;
                    nxt_t.min_tens = cur_t.min_tens + 1'b1;
                end else begin
                    nxt_t.min_ones = cur_t.min_ones + 1'b1;
                end
            end
        end else if (counting && tick) begin
            if (cur_t == '0) begin
                hit_n = 1'b1;
            end else if (cur_t == ONE_SEC) begin
                nxt_t = '0;
                hit_n = 1'b1;
            end else if (cur_t.sec_ones != '0) begin
                nxt_t.sec_ones = cur_t.sec_ones - 1'b1;
            end else if (cur_t.sec_tens != '0) begin
                nxt_t.sec_tens = cur_t.sec_tens - 1'b1;
                nxt_t.sec_ones = SO_MAX;
            end else begin
                nxt_t.sec_tens = ST_MAX;
                nxt_t.sec_ones = SO_MAX;
                if (cur_t.min_ones != '0) begin
                    nxt_t.min_ones = cur_t.min_ones - 1'b1;
                end else begin
                    nxt_t.min_tens = cur_t.min_tens - 1'b1;
                    nxt_t.min_ones = NINE;
                end
            end
        end
    end

    // Expiry goes through hit_q so finish lands one cycle after the digits read 00:00.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_t    <= '0;
            inc_s_d  <= 1'b1;
            inc_m_d  <= 1'b1;
            hit_q    <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            cur_t    <= nxt_t;
            inc_s_d  <= bus.incrementSeg;
            inc_m_d  <= bus.incrementMin;
            hit_q    <= hit_n;
            finish_q <= hit_q & ~bus.resetTimer;
        end
    end

`ifdef TIMER_EXPIRE_BLINK_EN
    always_ff @(posedge clk) begin
        if (reset || bus.resetTimer || inc_s_edge || inc_m_edge) begin
            expired <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            if (hit_q) begin
                expired <= 1'b1;
            end
            if (expired && tick) begin
                blink_q <= ~blink_q;
            end
        end
    end

    assign bus.blink = blink_q;
`endif

    assign bus.sec_ones = cur_t.sec_ones;
    assign bus.sec_tens = cur_t.sec_tens;
    assign bus.min_ones = cur_t.min_ones;
    assign bus.min_tens = cur_t.min_tens;
    assign bus.tick     = tick;
    assign bus.finish   = finish_q;
    assign bus.zero     = (cur_t == '0);

endmodule

// File: doc/timer_count_sequencer.md
Name: timer_count_sequencer

Overview:
- Executes the command levels from the timer control FSM against an MM:SS BCD time register.
- Runs a 1 Hz prescaler and applies, per clock, the command that wins arbitration: clear, set-increment, or countdown tick.
- Reports expiry back to the FSM as `finish`; the digits feed the VGA digit renderer.
- Sits between the control FSM and the display path. It owns the only writable copy of the time value.

Parameters:
- `CLK_HZ`, 50_000_000, input clock frequency in Hz.
- `TICK_HZ`, 1, countdown tick rate in Hz. `CLK_HZ / TICK_HZ` must be an integer ≥ 2.
- `MIN_MAX`, 99, highest minutes value; 1..99.

Ports:
- `clk` in 1: system clock. All logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `resetTimer` in 1: level; clears the time register and the prescaler.
- `enableCounter` in 1: level; counting or setting is allowed.
- `forward` in 1: level; 1 = setting mode (increments), 0 = countdown mode.
- `incrementSeg` in 1: level from FSM; acted on at its rising edge only.
- `incrementMin` in 1: level from FSM; acted on at its rising edge only.
- `sec_ones` out 4: BCD seconds units.
- `sec_tens` out 4: BCD seconds tens, 0..5.
- `min_ones` out 4: BCD minutes units.
- `min_tens` out 4: BCD minutes tens.
- `tick` out 1: 1-cycle pulse on each prescaler terminal count (debug/LED).
- `finish` out 1: 1-cycle pulse on expiry.
- `zero` out 1: combinational; 1 when the time register is 00:00.

Behaviour:
- **Reset:** `reset` sets all digits to 0, `tick` 0, `finish` 0, prescaler 0, and both edge-detect history flops to 1. The history value of 1 suppresses false edges from an FSM that powers up holding increments high.
- **Edge detect:** `inc_s_edge = incrementSeg & ~incrementSeg_d`; `inc_m_edge` is formed the same way. History flops update every cycle, including cycles where the edge is ignored.
- **Prescaler:**
  - Advances only when `enableCounter & ~forward`; otherwise it holds its value (pause keeps partial seconds).
  - Terminal count is `CLK_HZ/TICK_HZ-1`. At terminal count it wraps to 0 and `tick` pulses in that same cycle.
  - `resetTimer` zeroes it.
- **Per-cycle priority** (highest first; exactly one action per cycle):
  1. `reset`.
  2. `resetTimer`: digits ← 00:00, prescaler ← 0, `finish` 0.
  3. Setting, i.e. `enableCounter & forward`:
     - `inc_s_edge`: seconds +1; 59 wraps to 00 with no carry into minutes.
     - `inc_m_edge`: minutes +1; `MIN_MAX` wraps to 00.
     - Both edges in the same cycle: both applied.
  4. Countdown, i.e. `enableCounter & ~forward & tick`:
     - Value > 00:01: decrement by one second. `sec_ones` 0 borrows from `sec_tens`; seconds 00 becomes 59 and borrows one minute.
     - Value == 00:01: becomes 00:00; `finish` pulses on the next cycle.
     - Value == 00:00 at a tick: value held, `finish` pulses on the next cycle. This guarantees the FSM sees `finish` even when started at 00:00.
  5. Otherwise: hold.
- **Latency:**
  - Digit outputs are registered and update 1 cycle after the qualifying edge or tick.
  - `finish` is registered, so it is high in the cycle after the digits read 00:00.
- **Simultaneous events:**
  - `resetTimer` with any edge or tick: clear wins, edge consumed.
  - Increment edge while `forward=0`: ignored and lost, not queued.
  - Tick while `forward=1`: cannot occur, because the prescaler is frozen.
- **Mode changes mid-second:**
  - `forward` toggling mid-second keeps the prescaler phase.
  - `reset` mid-countdown returns everything to the reset values above.
- **Invariant:** digits are always valid BCD, with `sec_tens` ≤ 5 and minutes ≤ `MIN_MAX`.

Optional Feature:
- Macro: `TIMER_EXPIRE_BLINK_EN`.
- **When defined:**
  - Adds output `blink` (1 bit) and an internal `expired` flag.
  - `expired` sets with `finish` and clears on `resetTimer`, `reset`, or any increment edge.
  - While `expired`, `blink` toggles on every prescaler terminal count. The prescaler free-runs in this state regardless of `enableCounter`.
  - `blink` is 0 when not `expired`.
- **When undefined:** no `blink` port, no `expired` logic; the prescaler gating is exactly as above.

Decomposition:
- **Package `timer_pkg`:**
  - `BCD_W=4`.
  - `SEC_TENS_MAX=5`, `SEC_ONES_MAX=9`.
  - Function `prescale_max(CLK_HZ,TICK_HZ)`.
  - Typedef `time_bcd_t` (4×4-bit struct, mm:ss order).
  - Shared with the VGA digit renderer.
- **Sub-module `tick_prescaler`:** inputs `clk`, `reset`, `clr`, `run`, plus the optional `free_run`; output `tick`; parameter `DIV`. It is the natural split.
- BCD increment/decrement logic stays in the top module.

Test Plan (sim params: `CLK_HZ=10`, `TICK_HZ=1`, `MIN_MAX=99`):
1. **Basic countdown:** set 00:03 with 3 `incrementSeg` pulses, then `forward=0`, `enableCounter=1` → digits 00:02, 00:01, 00:00 every 10 cycles; `finish` high for exactly 1 cycle, 1 cycle after 00:00.
2. **Borrow chain:** load 10:00 via 10 `incrementMin` pulses, count 1 tick → 09:59. Load 01:00, 1 tick → 00:59.
3. **Wraps and held level:**
   - 60 `incrementSeg` edges from 00:00 → 00:00 with minutes unchanged.
   - 100 `incrementMin` edges → 00:00.
   - `incrementSeg` held high for 50 cycles → exactly +1.
4. **Priority:** at 05:30 counting, assert `resetTimer` in the same cycle as `tick` → 00:00, no `finish`, prescaler 0. Assert `incrementSeg` edge during countdown → ignored.
5. **Pause and zero start:** pause 4 cycles into a second, resume → next tick 6 cycles later. Start at 00:00 → `finish` pulse after the first tick, value stays 00:00.
6. **Blink (`TIMER_EXPIRE_BLINK_EN` defined):** after `finish`, `blink` toggles every 10 cycles; an `incrementSeg` edge drops `blink` to 0 and clears `expired`.
